// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit universal shift register with a start/busy/done
// command front end. A multi-bit shift or rotate runs one bit per clock under a
// two-state FSM (IDLE, SHIFT).
// Optional feature macro: SHIFT_ROTATE_EN. When it is defined, modes 100/101
// rotate left/right. When it is undefined, those modes act as single-cycle hold.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_ASHR  = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  localparam logic [AMT_W-1:0] AMT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_n;
  logic [2:0]       cap_mode;
  logic [2:0]       cap_mode_n;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] remaining_n;
  logic [WIDTH-1:0] q_n;
  logic             busy_n;
  logic             done_n;

  // Result of applying one operation (or one shift step) to the current value.
  function automatic logic [WIDTH-1:0] op_result(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             in_l,
    input logic             in_r,
    input logic [WIDTH-1:0] par
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      M_HOLD:  res = cur;
      M_LOAD:  res = par;
      M_SHL:   res = {cur[WIDTH-2:0], in_r};
      M_SHR:   res = {in_l, cur[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      M_ROTL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROTR:  res = {cur[0], cur[WIDTH-1:1]};
`else
      M_ROTL:  res = cur;
      M_ROTR:  res = cur;
`endif
      M_ASHR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLEAR: res = {WIDTH{1'b0}};
      default: res = cur;
    endcase
    return res;
  endfunction

  // True for modes that take amt steps; rotates only count when rotate logic exists.
  function automatic logic is_multi(input logic [2:0] op);
    logic r;
    case (op)
      M_SHL, M_SHR, M_ASHR: r = 1'b1;
`ifdef SHIFT_ROTATE_EN
      M_ROTL, M_ROTR:       r = 1'b1;
`endif
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state, next-data and handshake decode.
  always_comb begin
    state_n     = state;
    cap_mode_n  = cap_mode;
    remaining_n = remaining;
    q_n         = q;
    busy_n      = busy;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          cap_mode_n = mode;
          if (is_multi(mode)) begin
            if (amt == AMT_ZERO) begin
              q_n         = q;
              remaining_n = AMT_ZERO;
              done_n      = 1'b1;
            end else begin
              q_n         = op_result(mode, q, sin_l, sin_r, pin);
              remaining_n = amt - AMT_ONE;
              if (amt == AMT_ONE) begin
                done_n = 1'b1;
              end else begin
                state_n = SHIFT;
                busy_n  = 1'b1;
              end
            end
          end else begin
            q_n         = op_result(mode, q, sin_l, sin_r, pin);
            remaining_n = AMT_ZERO;
            done_n      = 1'b1;
          end
        end else begin
          q_n = q;
        end
      end
      SHIFT: begin
        q_n         = op_result(cap_mode, q, sin_l, sin_r, pin);
        remaining_n = remaining - AMT_ONE;
        if (remaining == AMT_ONE) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          busy_n = 1'b1;
        end
      end
      default: begin
        state_n     = IDLE;
        remaining_n = AMT_ZERO;
        busy_n      = 1'b0;
      end
    endcase
  end

  // State, data and handshake registers with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cap_mode  <= M_HOLD;
      remaining <= AMT_ZERO;
      q         <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cap_mode  <= cap_mode_n;
      remaining <= remaining_n;
      q         <= q_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule
